nn_loader: RTL and testbench

Front-end stage ahead of the layer controller. Pops a framed word stream from the host input FIFO and writes it into instruction, weight and XY memories. Issues a one-cycle `start` to the controller when it receives a RUN command. Holds off all FIFO traffic while the controller is busy, so memory contents never change under a running layer.

---
 rtl/nn_loader_pkg.sv | 35 +++
 rtl/nn_loader_inst_assembler.sv | 58 +++++
 rtl/nn_loader.sv | 233 +++++++++++++++++++++++
 tb/tb_nn_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_loader_pkg.sv
// nn_loader_pkg
// Shared definitions for the loader front-end: FSM state and packet target
// enums, the broadcast NU index and the bit positions of the H0 header fields.
package nn_loader_pkg;

    typedef enum logic [1:0] {
        HDR0    = 2'd0,
        HDR1    = 2'd1,
        PAYLOAD = 2'd2
    } LoaderState;

    typedef enum logic [1:0] {
        TGT_INST = 2'd0,
        TGT_W    = 2'd1,
        TGT_XY   = 2'd2,
        TGT_RUN  = 2'd3
    } LoaderTarget;

    localparam logic [5:0] LOADER_BROADCAST = 6'd63;

    // H0 field positions
    localparam int H0_TARGET_MSB = 15;
    localparam int H0_TARGET_LSB = 14;
    localparam int H0_NU_MSB     = 13;
    localparam int H0_NU_LSB     = 8;
    localparam int H0_COUNT_MSB  = 7;
    localparam int H0_COUNT_LSB  = 0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/nn_loader_inst_assembler.sv
// inst_assembler
// Collects K = INST_WIDTH/DATA_WIDTH sub-words (LSB word first) into one
// instruction. The instruction output is combinational and already includes
// the word presented this cycle, so the caller can register it together with
// the word_done strobe.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   clear            restart sub-word counting (start of a payload)
//   word_valid       a sub-word is consumed this cycle
//   word_data        the sub-word being consumed
//   instruction      assembled instruction including word_data
//   word_done        word_valid on the K-th sub-word
module inst_assembler #(
    parameter int DATA_WIDTH = 16,
    parameter int INST_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  word_valid,
    input  logic [DATA_WIDTH-1:0] word_data,
    output logic [INST_WIDTH-1:0] instruction,
    output logic                  word_done
);

    localparam int K  = INST_WIDTH / DATA_WIDTH;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    logic [CW-1:0]         sub_cnt_reg;
    logic [INST_WIDTH-1:0] shift_reg;
    logic [INST_WIDTH-1:0] shift_next;

    // New words enter at the top and move down, so the first word ends up in
    // the least significant slot once K words have arrived.
    generate
        if (K == 1) begin : g_single
            assign shift_next = word_data;
        end else begin : g_multi
            assign shift_next = {word_data, shift_reg[INST_WIDTH-1:DATA_WIDTH]};
        end
    endgenerate

    assign instruction = shift_next;
    assign word_done   = word_valid && (sub_cnt_reg == CW'(K - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sub_cnt_reg <= '0;
            shift_reg   <= '0;
        end else if (clear) begin
            sub_cnt_reg <= '0;
        end else if (word_valid) begin
            shift_reg   <= shift_next;
            sub_cnt_reg <= word_done ? '0 : sub_cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/nn_loader.sv
// nn_loader
// Pops a framed word stream from a first-word-fall-through FIFO and writes it
// into instruction, weight and XY memories; a RUN header produces a one-cycle
// start pulse. No word is popped while the controller reports ctrl_busy.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   buffer_empty/data/read_enable FIFO head and pop strobe
//   ctrl_busy                     controller executing; stalls all pops
//   inst_write_*                  instruction memory write port
//   w_write_*                     weight memory write port (per-bank enables)
//   xy_write_*                    XY memory write port
//   start                         one-cycle pulse after a RUN header pop
//   busy                          a packet is partially consumed
//   error                         sticky; bad NU index seen on a W packet
module nn_loader
    import nn_loader_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int NU_COUNT       = 8,
    parameter int INST_MEM_SIZE  = 64,
    parameter int INST_MEM_DEPTH = 8,
    parameter int W_MEM_DEPTH    = 10,
    parameter int XY_MEM_DEPTH   = 10
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      buffer_empty,
    input  logic [DATA_WIDTH-1:0]     buffer_data,
    output logic                      buffer_read_enable,
    input  logic                      ctrl_busy,
    output logic                      inst_write_enable,
    output logic [INST_MEM_DEPTH-1:0] inst_write_addr,
    output logic [INST_MEM_SIZE-1:0]  inst_write_data,
    output logic [NU_COUNT-1:0]       w_write_enable,
    output logic [W_MEM_DEPTH-1:0]    w_write_addr,
    output logic [DATA_WIDTH-1:0]     w_write_data,
    output logic                      xy_write_enable,
    output logic [XY_MEM_DEPTH-1:0]   xy_write_addr,
    output logic [DATA_WIDTH-1:0]     xy_write_data,
    output logic                      start,
    output logic                      busy,
    output logic                      error
);

    // One address counter serves all targets; each port takes its low bits,
    // which gives modulo-2^depth wrap for free.
    localparam int AW = max3(INST_MEM_DEPTH, W_MEM_DEPTH, XY_MEM_DEPTH);

    LoaderState  state_reg, state_next;
    LoaderTarget target_reg, target_next;
    logic [5:0]  nu_reg, nu_next;
    logic [7:0]  count_reg, count_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic        error_reg, error_next;
    logic        start_reg, start_next;

    logic                      inst_we_reg, inst_we_next;
    logic [INST_MEM_DEPTH-1:0] inst_addr_reg, inst_addr_next;
    logic [INST_MEM_SIZE-1:0]  inst_data_reg, inst_data_next;
    logic [NU_COUNT-1:0]       w_we_reg, w_we_next;
    logic [W_MEM_DEPTH-1:0]    w_addr_reg, w_addr_next;
    logic [DATA_WIDTH-1:0]     w_data_reg, w_data_next;
    logic                      xy_we_reg, xy_we_next;
    logic [XY_MEM_DEPTH-1:0]   xy_addr_reg, xy_addr_next;
    logic [DATA_WIDTH-1:0]     xy_data_reg, xy_data_next;

    logic                     pop;
    logic                     asm_clear;
    logic                     asm_valid;
    logic [INST_MEM_SIZE-1:0] asm_instruction;
    logic                     asm_word_done;
    logic [NU_COUNT-1:0]      nu_mask;
    logic [5:0]               h0_nu;
    logic                     h0_nu_bad;

    assign pop                = !buffer_empty && !ctrl_busy;
    assign buffer_read_enable = pop;

    // Bank enables: broadcast lights every bank; an out-of-range index lights
    // none, which is what suppresses writes for a bad W packet.
    genvar gi;
    generate
        for (gi = 0; gi < NU_COUNT; gi++) begin : g_nu_mask
            assign nu_mask[gi] = (nu_reg == LOADER_BROADCAST) || (nu_reg == 6'(gi));
        end
    endgenerate

    assign h0_nu     = buffer_data[H0_NU_MSB:H0_NU_LSB];
    assign h0_nu_bad = (h0_nu != LOADER_BROADCAST) && (32'(h0_nu) >= NU_COUNT);

    inst_assembler #(
        .DATA_WIDTH (DATA_WIDTH),
        .INST_WIDTH (INST_MEM_SIZE)
    ) u_asm (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (asm_clear),
        .word_valid  (asm_valid),
        .word_data   (buffer_data),
        .instruction (asm_instruction),
        .word_done   (asm_word_done)
    );

    always_comb begin
        state_next     = state_reg;
        target_next    = target_reg;
        nu_next        = nu_reg;
        count_next     = count_reg;
        addr_next      = addr_reg;
        error_next     = error_reg;
        start_next     = 1'b0;
        inst_we_next   = 1'b0;
        inst_addr_next = inst_addr_reg;
        inst_data_next = inst_data_reg;
        w_we_next      = '0;
        w_addr_next    = w_addr_reg;
        w_data_next    = w_data_reg;
        xy_we_next     = 1'b0;
        xy_addr_next   = xy_addr_reg;
        xy_data_next   = xy_data_reg;
        asm_clear      = 1'b0;
        asm_valid      = 1'b0;

        case (state_reg)
            HDR0: begin
                if (pop) begin
                    target_next = LoaderTarget'(buffer_data[H0_TARGET_MSB:H0_TARGET_LSB]);
                    nu_next     = h0_nu;
                    count_next  = buffer_data[H0_COUNT_MSB:H0_COUNT_LSB];
                    if (target_next == TGT_RUN) begin
                        start_next = 1'b1;
                    end else begin
                        state_next = HDR1;
                        if (target_next == TGT_W && h0_nu_bad) begin
                            error_next = 1'b1;
                        end
                    end
                end
            end
            HDR1: begin
                if (pop) begin
                    addr_next  = AW'(buffer_data);
                    asm_clear  = 1'b1;
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (pop) begin
                    if (target_reg == TGT_INST) begin
                        asm_valid = 1'b1;
                        if (asm_word_done) begin
                            inst_we_next   = 1'b1;
                            inst_addr_next = addr_reg[INST_MEM_DEPTH-1:0];
                            inst_data_next = asm_instruction;
                        end
                    end else if (target_reg == TGT_W) begin
                        w_we_next   = nu_mask;
                        w_addr_next = addr_reg[W_MEM_DEPTH-1:0];
                        w_data_next = buffer_data;
                    end else begin
                        xy_we_next   = 1'b1;
                        xy_addr_next = addr_reg[XY_MEM_DEPTH-1:0];
                        xy_data_next = buffer_data;
                    end

                    // An item ends on every W/XY word, but only on the
                    // K-th sub-word of an instruction.
                    if (target_reg != TGT_INST || asm_word_done) begin
                        addr_next = addr_reg + AW'(1);
                        if (count_reg == 8'd0) begin
                            state_next = HDR0;
                        end else begin
                            count_next = count_reg - 8'd1;
                        end
                    end
                end
            end
            default: state_next = HDR0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= HDR0;
            target_reg    <= TGT_INST;
            nu_reg        <= '0;
            count_reg     <= '0;
            addr_reg      <= '0;
            error_reg     <= 1'b0;
            start_reg     <= 1'b0;
            inst_we_reg   <= 1'b0;
            inst_addr_reg <= '0;
            inst_data_reg <= '0;
            w_we_reg      <= '0;
            w_addr_reg    <= '0;
            w_data_reg    <= '0;
            xy_we_reg     <= 1'b0;
            xy_addr_reg   <= '0;
            xy_data_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            target_reg    <= target_next;
            nu_reg        <= nu_next;
            count_reg     <= count_next;
            addr_reg      <= addr_next;
            error_reg     <= error_next;
            start_reg     <= start_next;
            inst_we_reg   <= inst_we_next;
            inst_addr_reg <= inst_addr_next;
            inst_data_reg <= inst_data_next;
            w_we_reg      <= w_we_next;
            w_addr_reg    <= w_addr_next;
            w_data_reg    <= w_data_next;
            xy_we_reg     <= xy_we_next;
            xy_addr_reg   <= xy_addr_next;
            xy_data_reg   <= xy_data_next;
        end
    end

    assign inst_write_enable = inst_we_reg;
    assign inst_write_addr   = inst_addr_reg;
    assign inst_write_data   = inst_data_reg;
    assign w_write_enable    = w_we_reg;
    assign w_write_addr      = w_addr_reg;
    assign w_write_data      = w_data_reg;
    assign xy_write_enable   = xy_we_reg;
    assign xy_write_addr     = xy_addr_reg;
    assign xy_write_data     = xy_data_reg;
    assign start             = start_reg;
    assign busy              = (state_reg != HDR0);
    assign error             = error_reg;

endmodule

// File: tb/tb_nn_loader.sv
// tb_nn_loader
// Directed bench for nn_loader: a queue models the FWFT input FIFO, a negedge
// monitor logs every memory write, and one initial block runs the scenarios.
module tb_nn_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        buffer_empty;
    logic [15:0] buffer_data;
    logic        buffer_read_enable;
    logic        ctrl_busy;
    logic        inst_write_enable;
    logic [7:0]  inst_write_addr;
    logic [63:0] inst_write_data;
    logic [7:0]  w_write_enable;
    logic [9:0]  w_write_addr;
    logic [15:0] w_write_data;
    logic        xy_write_enable;
    logic [9:0]  xy_write_addr;
    logic [15:0] xy_write_data;
    logic        start;
    logic        busy;
    logic        error;

    always #5 clk = ~clk;

    nn_loader dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .buffer_empty       (buffer_empty),
        .buffer_data        (buffer_data),
        .buffer_read_enable (buffer_read_enable),
        .ctrl_busy          (ctrl_busy),
        .inst_write_enable  (inst_write_enable),
        .inst_write_addr    (inst_write_addr),
        .inst_write_data    (inst_write_data),
        .w_write_enable     (w_write_enable),
        .w_write_addr       (w_write_addr),
        .w_write_data       (w_write_data),
        .xy_write_enable    (xy_write_enable),
        .xy_write_addr      (xy_write_addr),
        .xy_write_data      (xy_write_data),
        .start              (start),
        .busy               (busy),
        .error              (error)
    );

    typedef struct {
        logic [7:0]  en;
        logic [15:0] addr;
        logic [63:0] data;
    } wr_t;

    logic [15:0] fifo[$];
    wr_t         inst_log[$];
    wr_t         w_log[$];
    wr_t         xy_log[$];
    int          pop_count = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        do_pop;
    logic [15:0] junk;

    task automatic refresh();
        buffer_empty = (fifo.size() == 0);
        buffer_data  = (fifo.size() == 0) ? 16'h0 : fifo[0];
    endtask

    task automatic push(input logic [15:0] w);
        fifo.push_back(w);
        refresh();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((fifo.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(n < budget), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // FIFO model: the pop decision is taken at the edge, the head advances
    // just after it so the DUT samples the old head.
    always @(posedge clk) begin
        do_pop = buffer_read_enable;
        #1;
        if (do_pop && fifo.size() > 0) begin
            junk = fifo.pop_front();
            pop_count++;
        end
        refresh();
    end

    always @(negedge clk) begin
        if (inst_write_enable) begin
            inst_log.push_back('{8'h1, 16'(inst_write_addr), inst_write_data});
            $display("inst write addr=%h data=%h", inst_write_addr, inst_write_data);
        end
        if (w_write_enable != 8'h0) begin
            w_log.push_back('{w_write_enable, 16'(w_write_addr), 64'(w_write_data)});
            $display("w write en=%b addr=%h data=%h", w_write_enable, w_write_addr, w_write_data);
        end
        if (xy_write_enable) begin
            xy_log.push_back('{8'h1, 16'(xy_write_addr), 64'(xy_write_data)});
            $display("xy write addr=%h data=%h", xy_write_addr, xy_write_data);
        end
        if (start) $display("start pulse at %0t", $time);
    end

    initial begin
        int n;
        int p0;
        int s0;
        int wb;
        int ib;

        reset_n   = 1'b0;
        ctrl_busy = 1'b0;
        refresh();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_inst_we", 64'(inst_write_enable), 64'd0);
        chk("rst_inst_addr", 64'(inst_write_addr), 64'd0);
        chk("rst_inst_data", inst_write_data, 64'd0);
        chk("rst_w_we", 64'(w_write_enable), 64'd0);
        chk("rst_xy_we", 64'(xy_write_enable), 64'd0);
        chk("rst_start", 64'(start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // INST load: two instructions of four words each
        push(16'h0001);
        push(16'h0010);
        for (int i = 0; i < 8; i++) push(16'(i));
        wait_idle(40);
        chk("inst_count", 64'(inst_log.size()), 64'd2);
        if (inst_log.size() == 2) begin
            chk("inst0_addr", 64'(inst_log[0].addr), 64'h10);
            chk("inst0_data", inst_log[0].data, 64'h0003_0002_0001_0000);
            chk("inst1_addr", 64'(inst_log[1].addr), 64'h11);
            chk("inst1_data", inst_log[1].data, 64'h0007_0006_0005_0004);
        end

        // W broadcast
        push(16'h7F00);
        push(16'h03FF);
        push(16'hABCD);
        wait_idle(20);
        chk("wb_count", 64'(w_log.size()), 64'd1);
        if (w_log.size() == 1) begin
            chk("wb_en", 64'(w_log[0].en), 64'hFF);
            chk("wb_addr", 64'(w_log[0].addr), 64'h3FF);
            chk("wb_data", w_log[0].data, 64'hABCD);
        end

        // W single bank with address wrap
        push(16'h4202);
        push(16'h03FF);
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        wait_idle(20);
        chk("ws_count", 64'(w_log.size()), 64'd4);
        if (w_log.size() == 4) begin
            chk("ws0_en", 64'(w_log[1].en), 64'h04);
            chk("ws0_addr", 64'(w_log[1].addr), 64'h3FF);
            chk("ws0_data", w_log[1].data, 64'h1111);
            chk("ws1_addr", 64'(w_log[2].addr), 64'h000);
            chk("ws1_data", w_log[2].data, 64'h2222);
            chk("ws2_en", 64'(w_log[3].en), 64'h04);
            chk("ws2_addr", 64'(w_log[3].addr), 64'h001);
            chk("ws2_data", w_log[3].data, 64'h3333);
        end

        // XY with a 5-cycle controller stall mid-payload
        push(16'h8007);
        push(16'h0100);
        for (int i = 0; i < 8; i++) push(16'h0050 + 16'(i));
        n = 0;
        while (xy_log.size() < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reach_timeout", 64'(n < 50), 64'd1);
        ctrl_busy = 1'b1;
        p0 = pop_count;
        @(negedge clk);
        s0 = xy_log.size();
        repeat (4) begin
            @(negedge clk);
            chk("stall_read_enable", 64'(buffer_read_enable), 64'd0);
        end
        chk("stall_pops", 64'(pop_count), 64'(p0));
        chk("stall_writes", 64'(xy_log.size()), 64'(s0));
        chk("stall_busy", 64'(busy), 64'd1);
        ctrl_busy = 1'b0;
        wait_idle(40);
        chk("xy_count", 64'(xy_log.size()), 64'd8);
        if (xy_log.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("xy%0d_addr", i), 64'(xy_log[i].addr), 64'h100 + 64'(i));
                chk($sformatf("xy%0d_data", i), xy_log[i].data, 64'h50 + 64'(i));
            end
        end

        // RUN: start one cycle after the pop, exactly one cycle wide
        chk("run_pre_start", 64'(start), 64'd0);
        push(16'hC000);
        @(negedge clk);
        chk("run_start", 64'(start), 64'd1);
        chk("run_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("run_start_off", 64'(start), 64'd0);
        chk("run_busy_after", 64'(busy), 64'd0);

        // Bad NU index: payload consumed, no write, sticky error
        wb = w_log.size();
        push(16'h4A00);
        push(16'h0000);
        push(16'h1234);
        wait_idle(20);
        chk("bad_nu_no_write", 64'(w_log.size()), 64'(wb));
        chk("bad_nu_error", 64'(error), 64'd1);
        chk("bad_nu_fifo_drained", 64'(fifo.size()), 64'd0);
        push(16'h8000);
        push(16'h0020);
        push(16'h9999);
        wait_idle(20);
        chk("error_sticky", 64'(error), 64'd1);
        chk("after_bad_xy_count", 64'(xy_log.size()), 64'd9);
        if (xy_log.size() == 9) begin
            chk("after_bad_xy_addr", 64'(xy_log[8].addr), 64'h020);
            chk("after_bad_xy_data", xy_log[8].data, 64'h9999);
        end

        // Reset in the middle of an INST payload
        ib = inst_log.size();
        push(16'h0000);
        push(16'h0005);
        push(16'hAAAA);
        push(16'hBBBB);
        n = 0;
        while (fifo.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midpkt_timeout", 64'(n < 20), 64'd1);
        chk("midpkt_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_error", 64'(error), 64'd0);
        chk("midrst_start", 64'(start), 64'd0);
        chk("midrst_inst_addr", 64'(inst_write_addr), 64'd0);
        chk("midrst_w_addr", 64'(w_write_addr), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        push(16'hC000);
        @(negedge clk);
        chk("postrst_start", 64'(start), 64'd1);
        chk("postrst_no_inst", 64'(inst_log.size()), 64'(ib));

        // A fresh instruction after reset assembles cleanly
        push(16'h0000);
        push(16'h0007);
        for (int i = 1; i <= 4; i++) push(16'(i));
        wait_idle(20);
        chk("postrst_inst_count", 64'(inst_log.size()), 64'(ib + 1));
        if (inst_log.size() == ib + 1) begin
            chk("postrst_inst_addr", 64'(inst_log[ib].addr), 64'h07);
            chk("postrst_inst_data", inst_log[ib].data, 64'h0004_0003_0002_0001);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
